// File: rtl/serial_paralelo_rx_if.sv
// Line-side bundle of the RX serial-to-parallel aligner: serial bit in, aligned byte out.
// master drives the line and sinks the bytes; slave is the aligner itself.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel converter and COM-based byte aligner at the head of the PHY RX demux chain.
// Locks after LOCK_COUNT consecutive aligned COMs, then emits one byte every 8 clocks with a valid flag.
module serial_paralelo_rx #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input logic                 clk_32f,
  input logic                 reset,
  serial_paralelo_rx_if.slave bus
);

  localparam int CW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ALIGNING = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  // Only the low 7 bits of the shift register are ever read, so the MSB is not stored.
  logic [6:0]     sr_q, sr_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]  com_cnt_q, com_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           active_q, active_d;

  logic [7:0]     w;
  logic           is_com;
  logic           byte_done;
  logic           lock;

  assign w         = {sr_q, bus.data_in};
  assign is_com    = (w == COM);
  assign byte_done = (bit_cnt_q == 3'd7);
  assign sr_d      = w[6:0];

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    lock      = 1'b0;
    case (state_q)
      SEARCH: begin
        if (is_com) begin
          bit_cnt_d = '0;
          com_cnt_d = CW'(1);
          if (LOCK_COUNT == 1) begin
            state_d = ACTIVE;
            lock    = 1'b1;
          end else begin
            state_d = ALIGNING;
          end
        end
      end
      ALIGNING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + CW'(1);
            if (int'(com_cnt_q) + 1 == LOCK_COUNT) begin
              state_d = ACTIVE;
              lock    = 1'b1;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Registered outputs: the lock edge presents COM, later completions present the new byte.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    active_d = active_q;
    if (lock) begin
      active_d = 1'b1;
      data_d   = COM;
      valid_d  = 1'b0;
    end else if (state_q == ACTIVE && byte_done) begin
      data_d  = w;
      valid_d = !is_com;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: reset, lock, misalignment, broken lock, idle and mid-run reset.
module tb_serial_paralelo_rx;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  serial_paralelo_rx_if bus ();

  serial_paralelo_rx #(
    .COM        (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .clk_32f (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // {active, valid_out, data_out}
  logic [9:0] obs;
  assign obs = {bus.active, bus.valid_out, bus.data_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one bit, let the DUT sample it, then settle just after the edge.
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Optionally verify that the previous output stays put during the first 7 bits.
  task automatic send_byte(input logic [7:0] b, input bit hold, input logic [9:0] hexp);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (hold && i != 0) chk("hold", obs, hexp);
    end
  endtask

  task automatic pulse_reset(input int unsigned n);
    reset = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      send_bit(k[0]);
      chk("reset", obs, 10'h000);
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    bus.data_in = 1'b0;
    #2;

    // Reset held 3 edges with data toggling.
    pulse_reset(3);

    // Clean lock: 4x BC then 5A, FF.
    send_byte(8'hBC, 0, '0); chk("lock_bc1", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("lock_bc2", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("lock_bc3", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("lock_bit32", obs, {1'b1, 1'b0, 8'hBC});
    send_byte(8'h5A, 1, {1'b1, 1'b0, 8'hBC}); chk("lock_bit40", obs, {1'b1, 1'b1, 8'h5A});
    send_byte(8'hFF, 1, {1'b1, 1'b1, 8'h5A}); chk("lock_bit48", obs, {1'b1, 1'b1, 8'hFF});

    // Misaligned start: 1,0,1 then 4x BC then 3C.
    pulse_reset(1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("mis_pre", obs, 10'h000);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0); chk("mis_bit27", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("mis_bit35", obs, {1'b1, 1'b0, 8'hBC});
    send_byte(8'h3C, 1, {1'b1, 1'b0, 8'hBC}); chk("mis_bit43", obs, {1'b1, 1'b1, 8'h3C});

    // Broken lock: BC,BC,00,BC,BC,BC,BC,A5.
    pulse_reset(1);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0);
    send_byte(8'h00, 0, '0); chk("brk_zero", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("brk_b4", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("brk_b5", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("brk_b6", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("brk_b7", obs, {1'b1, 1'b0, 8'hBC});
    send_byte(8'hA5, 1, {1'b1, 1'b0, 8'hBC}); chk("brk_b8", obs, {1'b1, 1'b1, 8'hA5});

    // Idle inside ACTIVE: 11, BC, 22 with 8-cycle holds.
    send_byte(8'h11, 1, {1'b1, 1'b1, 8'hA5}); chk("idle_11", obs, {1'b1, 1'b1, 8'h11});
    send_byte(8'hBC, 1, {1'b1, 1'b1, 8'h11}); chk("idle_bc", obs, {1'b1, 1'b0, 8'hBC});
    send_byte(8'h22, 1, {1'b1, 1'b0, 8'hBC}); chk("idle_22", obs, {1'b1, 1'b1, 8'h22});

    // Reset for one edge in the middle of a data byte.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("mid_pre", obs, {1'b1, 1'b1, 8'h22});
    pulse_reset(1);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0); chk("rst_bc3", obs, 10'h000);
    send_byte(8'h5A, 0, '0); chk("rst_data", obs, 10'h000);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0);
    send_byte(8'hBC, 0, '0); chk("relock_bc3", obs, 10'h000);
    send_byte(8'hBC, 0, '0); chk("relock_bc4", obs, {1'b1, 1'b0, 8'hBC});
    send_byte(8'h77, 1, {1'b1, 1'b0, 8'hBC}); chk("relock_77", obs, {1'b1, 1'b1, 8'h77});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
